// File: rtl/instruction_loader_if.sv
// Word-stream handshake and instruction-memory byte-write bus for instruction_loader.
// The master side is the host/boot source together with the memory it fills;
// the slave side is the loader itself.
interface instruction_loader_if;
  logic [31:0] WordIn;
  logic        WordValid;
  logic        WordLast;
  logic        WordReady;
  logic        MemWE;
  logic [31:0] MemAddr;
  logic [7:0]  MemData;
  logic [5:0]  WordCount;
  logic        Done;

  modport master (
    output WordIn, WordValid, WordLast,
    input  WordReady, MemWE, MemAddr, MemData, WordCount, Done
  );

  modport slave (
    input  WordIn, WordValid, WordLast,
    output WordReady, MemWE, MemAddr, MemData, WordCount, Done
  );
endinterface

// File: rtl/instruction_loader.sv
// Byte-serial instruction memory loader: accepts 32-bit words over valid/ready
// and writes each as four big-endian bytes at consecutive byte addresses.
// Every output is decoded from registered state only, so no input reaches an
// output combinationally.
module instruction_loader #(
  parameter longint unsigned DEPTH = 128
) (
  input  logic                  CLK,
  input  logic                  Reset,
  input  logic                  Start,
  instruction_loader_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCEPT = 2'd1,
    S_WRITE  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  // DEPTH may be as large as 2^32, so the end-of-memory compare is done in 33 bits.
  localparam logic [32:0] DEPTH_W = DEPTH[32:0];

  state_t      state_q, state_d;
  logic [31:0] base_q,  base_d;
  logic [1:0]  idx_q,   idx_d;
  logic [31:0] word_q,  word_d;
  logic        last_q,  last_d;
  logic [5:0]  count_q, count_d;

  logic [32:0] next_base_w;
  assign next_base_w = {1'b0, base_q} + 33'd4;

  // State and datapath registers; Reset clears everything immediately.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      base_q  <= '0;
      idx_q   <= '0;
      word_q  <= '0;
      last_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      last_q  <= last_d;
      count_q <= count_d;
    end
  end

  // Next-state logic; Start overrides everything, including a same-cycle handshake.
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    idx_d   = idx_q;
    word_d  = word_q;
    last_d  = last_q;
    count_d = count_q;
    if (Start) begin
      state_d = S_ACCEPT;
      base_d  = '0;
      idx_d   = '0;
      count_d = '0;
    end else begin
      case (state_q)
        S_ACCEPT: begin
          if (bus.WordValid) begin
            word_d  = bus.WordIn;
            last_d  = bus.WordLast;
            idx_d   = '0;
            state_d = S_WRITE;
          end
        end
        S_WRITE: begin
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            base_d  = next_base_w[31:0];
            count_d = (count_q == 6'd63) ? count_q : count_q + 6'd1;
            if (last_q || (next_base_w == DEPTH_W)) begin
              state_d = S_DONE;
            end else begin
              state_d = S_ACCEPT;
            end
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  // Output decode; the memory bus is held at zero outside WRITE.
  always_comb begin
    bus.WordReady = (state_q == S_ACCEPT);
    bus.Done      = (state_q == S_DONE);
    bus.WordCount = count_q;
    bus.MemWE     = 1'b0;
    bus.MemAddr   = '0;
    bus.MemData   = '0;
    if (state_q == S_WRITE) begin
      bus.MemWE   = 1'b1;
      bus.MemAddr = base_q + {30'd0, idx_q};
      case (idx_q)
        2'd0:    bus.MemData = word_q[31:24];
        2'd1:    bus.MemData = word_q[23:16];
        2'd2:    bus.MemData = word_q[15:8];
        default: bus.MemData = word_q[7:0];
      endcase
    end
  end

endmodule

// File: doc/instruction_loader.md
# instruction_loader

Byte-serial writer that fills the multi-cycle CPU's 128-byte instruction memory from a 32-bit word stream, replacing the `$readmemb` file preload at run time. It accepts words over a valid/ready handshake and writes each one as four big-endian bytes: byte address A gets bits [31:24], A+1 gets [23:16], A+2 gets [15:8], and A+3 gets [7:0]. The CPU fetch path reads the words back unchanged. The block sits between a host/boot source and the instruction memory write port, and the CPU is held in reset until `Done` is asserted.

## Interface
- `DEPTH`, default 128: instruction memory size in bytes. It must be a multiple of 4 and at most 2^32.
- `CLK` input, 1 bit: the single clock. All state changes on its rising edge.
- `Reset` input, 1 bit: asynchronous, active-high reset.
- `Start` input, 1 bit: single-cycle pulse that begins or restarts a load at byte address 0.
- `WordIn` input, 32 bits: instruction word to store.
- `WordValid` input, 1 bit: `WordIn` is valid.
- `WordLast` input, 1 bit: qualifies `WordIn` as the final word of the image.
- `WordReady` output, 1 bit: the loader can accept a word this cycle.
- `MemWE` output, 1 bit: byte write enable to the instruction memory.
- `MemAddr` output, 32 bits: byte address for the write.
- `MemData` output, 8 bits: byte to write.
- `WordCount` output, 6 bits: number of words fully written since the last `Start`.
- `Done` output, 1 bit: load finished; held until the next `Start` or `Reset`.

## Operation
- States:
  - IDLE: after reset.
  - ACCEPT: `WordReady` = 1.
  - WRITE: 4 cycles, byte index 0..3.
  - DONE: `Done` = 1.
- Reset value of every output and register is 0, and the state is IDLE.
- IDLE → ACCEPT on `Start`. At that transition, base address = 0 and `WordCount` = 0.
- ACCEPT: a handshake occurs when `WordValid` and `WordReady` are both 1 at a rising edge. On a handshake:
  - `WordIn` is latched into a holding register.
  - `WordLast` is latched into a last flag.
  - Byte index is set to 0.
  - The state moves to WRITE.
- WRITE, byte index i:
  - `MemWE` = 1.
  - `MemAddr` = base + i.
  - `MemData` = held word bits [31-8i : 24-8i].
  - i increments each cycle.
- After i = 3:
  - base += 4 and `WordCount` += 1.
  - If the last flag is set, or base + 4 = `DEPTH`, go to DONE.
  - Otherwise go to ACCEPT.
- DONE: `Done` = 1, `WordReady` = 0, `MemWE` = 0. The block stays in DONE until `Start`.
- `Start` in any state (ACCEPT, WRITE or DONE) aborts the current word and returns to ACCEPT with base = 0, `WordCount` = 0 and `Done` = 0.
  - A byte written in the cycle before `Start` is left in memory; no rollback.
  - `Start` has priority over a handshake in the same cycle, and that word is dropped.
- `WordValid` while `WordReady` = 0 is ignored. The source must hold the word until it sees the handshake.
- Address arithmetic: 32-bit unsigned; `MemAddr` never reaches `DEPTH`. `WordCount` saturates at 63, which is unreachable for `DEPTH` = 128.
- Outputs in IDLE and ACCEPT: `MemWE` = 0, `MemAddr` = 0, `MemData` = 0.

## Timing
- `WordReady`, `MemWE`, `MemAddr`, `MemData`, `Done` and `WordCount` are all registered or decoded from state/registers only. None is combinational from any input.
- For a handshake at edge N:
  - `MemWE` is high for the 4 cycles following edge N, with addresses base..base+3.
  - `WordReady` is high again in the cycle after edge N+4, or `Done` is high instead.
- Throughput: one word per 5 cycles when `WordValid` is held high.
- Latency: the first byte is written at edge N+1 and the last byte at edge N+4.
- `Done` rises in the cycle after the final byte's write edge.
- Asynchronous `Reset` forces IDLE and zero outputs immediately, mid-word included. The memory contents are not touched.
- `Start` is sampled synchronously; `Reset` wins over `Start`.

## Test plan
- **Basic load.** Stimulus: `Start`, then words 0x8C010004, 0x00221820, 0xAC030008 with `WordLast` on the third word. Required response:
  - Memory bytes 0..11 = 8C 01 00 04 00 22 18 20 AC 03 00 08.
  - `WordCount` = 3 and `Done` = 1.
  - Reading back through the 4-byte big-endian fetch returns the same three words.
- **Handshake timing.** Stimulus: `WordValid` held high continuously. Required response:
  - `WordReady` pulses every 5 cycles.
  - Exactly 4 `MemWE` cycles per word, with no write while `WordReady` = 1.
  - `WordValid` low for 3 cycles stalls the loader with `MemWE` = 0.
- **Full memory.** Stimulus: 32 words with `WordLast` never asserted. Required response:
  - Last write is to `MemAddr` = 127.
  - `Done` = 1 and `WordCount` = 32.
  - A 33rd word is not accepted (`WordReady` = 0).
- **Restart mid-word.** Stimulus: `Start` during WRITE byte index 2 of word 5. Required response:
  - Next state is ACCEPT with `WordCount` = 0.
  - The next word is written at addresses 0..3.
- **Async reset mid-write.** Stimulus: `Reset` asserted between clock edges during WRITE. Required response:
  - `MemWE`, `WordReady`, `Done` and `MemAddr` go to 0 before the next edge.
  - State is IDLE, and `Start` is needed to resume.
- **Simultaneous `Start` and handshake.** Stimulus: `Start` and a valid handshake in the same ACCEPT cycle. Required response:
  - The word is dropped and no `MemWE` follows.
  - `WordReady` = 1 in the next cycle.
